// File: rtl/axil_traffic_gen_pkg.sv
// axil_traffic_gen_pkg
//   Shared types for the AXI-Lite traffic generator: FSM state encoding,
//   data pattern select encoding, protection constant and a saturating
//   16-bit increment used by the error counters.
//   Optional feature macro in the top: AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN.
package axil_traffic_gen_pkg;

   typedef enum logic [2:0] {
      e_idle,
      e_write,
      e_write_resp,
      e_read_addr,
      e_read_data,
      e_done
   } state_e;

   // Pattern 2'b11 is reserved and behaves like the address pattern.
   typedef enum logic [1:0] {
      PAT_ADDR     = 2'b00,
      PAT_INV      = 2'b01,
      PAT_ONEHOT   = 2'b10,
      PAT_ADDR_ALT = 2'b11
   } pattern_e;

   // Unprivileged-off, secure, data access
   localparam logic [2:0] AXPROT = 3'b001;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axil_traffic_pattern_gen.sv
// axil_traffic_pattern_gen
//   Combinational data pattern generator shared by the write data path and
//   the read check path.
//   Ports:
//     index_i  word index within the pass
//     addr_i   byte address of that word
//     mode_i   pattern select
//     data_o   generated data word
module axil_traffic_pattern_gen
   import axil_traffic_gen_pkg::*;
#(
   parameter int addr_width_p = 28,
   parameter int data_width_p = 64
) (
   input  logic [31:0]             index_i,
   input  logic [addr_width_p-1:0] addr_i,
   input  pattern_e                mode_i,
   output logic [data_width_p-1:0] data_o
);

   logic [data_width_p-1:0] addr_ext;
   logic [data_width_p-1:0] one;

   assign addr_ext = data_width_p'(addr_i);
   assign one      = data_width_p'(1);

   always_comb begin
      data_o = addr_ext;
      case (mode_i)
         PAT_INV:    data_o = ~addr_ext;
         PAT_ONEHOT: data_o = one << (index_i % 32'(data_width_p));
         default:    data_o = addr_ext;
      endcase
   end

endmodule

// File: rtl/axil_traffic_gen.sv
// axil_traffic_gen
//   AXI-Lite traffic generator. On start_i it writes num_words_p words
//   (one outstanding transaction at a time) starting at base_addr_p, then
//   reads them back and counts response and data errors.
//   Ports:
//     clk_i, reset_i          clock, synchronous active-high reset
//     start_i, pattern_i      begin a pass / pattern select (sampled at start)
//     busy_o, done_o          pass in progress / pass complete
//     aw*, w*, b*             AXI-Lite write channels (master side)
//     ar*, r*                 AXI-Lite read channels (master side)
//     wr_err_cnt_o            saturating count of SLVERR/DECERR write responses
//     rd_err_cnt_o            saturating count of bad read responses or data
//     err_addr_o, err_data_o  first read mismatch address/data, only when
//                             AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN is defined
module axil_traffic_gen
   import axil_traffic_gen_pkg::*;
#(
   parameter int addr_width_p = 28,
   parameter int data_width_p = 64,
   parameter int base_addr_p  = 0,
   parameter int num_words_p  = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      start_i,
   input  logic [1:0]                pattern_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [addr_width_p-1:0]   awaddr_o,
   output logic [2:0]                awprot_o,
   output logic                      awvalid_o,
   input  logic                      awready_i,
   output logic [data_width_p-1:0]   wdata_o,
   output logic [data_width_p/8-1:0] wstrb_o,
   output logic                      wvalid_o,
   input  logic                      wready_i,
   input  logic [1:0]                bresp_i,
   input  logic                      bvalid_i,
   output logic                      bready_o,
   output logic [addr_width_p-1:0]   araddr_o,
   output logic [2:0]                arprot_o,
   output logic                      arvalid_o,
   input  logic                      arready_i,
   input  logic [data_width_p-1:0]   rdata_i,
   input  logic [1:0]                rresp_i,
   input  logic                      rvalid_i,
   output logic                      rready_o,
   output logic [15:0]               wr_err_cnt_o,
   output logic [15:0]               rd_err_cnt_o
`ifdef AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN
   ,
   output logic [addr_width_p-1:0]   err_addr_o,
   output logic [data_width_p-1:0]   err_data_o
`endif
);

   localparam int BYTES = data_width_p / 8;
   localparam int IDX_W = (num_words_p > 1) ? $clog2(num_words_p) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_words_p - 1);

   state_e                  state_q;
   logic [IDX_W-1:0]        idx_q, idx_d;
   pattern_e                mode_q, mode_d;
   logic [addr_width_p-1:0] addr_q, addr_d;
   logic [data_width_p-1:0] data_q, pat_data;
   logic                    is_last, aw_ok, w_ok, rd_bad;
   logic                    unused_resp;

   // Only bit 1 of a response distinguishes OKAY/EXOKAY from errors.
   assign unused_resp = ^{bresp_i[0], rresp_i[0]};

   assign is_last = (idx_q == LAST_IDX);
   // A channel is finished when it was accepted earlier or is accepted now.
   assign aw_ok   = !awvalid_o || awready_i;
   assign w_ok    = !wvalid_o || wready_i;
   // data_q always holds the pattern of the current index, so it doubles as
   // the write data and the read-check reference.
   assign rd_bad  = (rdata_i != data_q);

   assign awaddr_o = addr_q;
   assign araddr_o = addr_q;
   assign wdata_o  = data_q;
   assign wstrb_o  = '1;
   assign awprot_o = AXPROT;
   assign arprot_o = AXPROT;

   // Next index/mode are computed here so that address and pattern can be
   // registered in the same edge the FSM moves to the new word.
   always_comb begin
      idx_d  = idx_q;
      mode_d = mode_q;
      case (state_q)
         e_idle, e_done:
            if (start_i) begin
               idx_d  = '0;
               mode_d = pattern_e'(pattern_i);
            end
         e_write_resp:
            if (bvalid_i) idx_d = is_last ? '0 : idx_q + IDX_W'(1);
         e_read_data:
            if (rvalid_i && !is_last) idx_d = idx_q + IDX_W'(1);
         default: ;
      endcase
      if (reset_i) begin
         idx_d  = '0;
         mode_d = PAT_ADDR;
      end
   end

   assign addr_d = addr_width_p'(64'(base_addr_p) + 64'(idx_d) * 64'(BYTES));

   axil_traffic_pattern_gen #(
      .addr_width_p(addr_width_p),
      .data_width_p(data_width_p)
   ) u_pat (
      .index_i(32'(idx_d)),
      .addr_i (addr_d),
      .mode_i (mode_d),
      .data_o (pat_data)
   );

`ifdef AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN
   logic err_seen_q;
`endif

   always_ff @(posedge clk_i) begin
      idx_q  <= idx_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      data_q <= pat_data;
      if (reset_i) begin
         state_q      <= e_idle;
         awvalid_o    <= 1'b0;
         wvalid_o     <= 1'b0;
         bready_o     <= 1'b0;
         arvalid_o    <= 1'b0;
         rready_o     <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         wr_err_cnt_o <= '0;
         rd_err_cnt_o <= '0;
`ifdef AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN
         err_seen_q   <= 1'b0;
         err_addr_o   <= '0;
         err_data_o   <= '0;
`endif
      end else begin
         case (state_q)
            e_idle, e_done:
               if (start_i) begin
                  state_q      <= e_write;
                  awvalid_o    <= 1'b1;
                  wvalid_o     <= 1'b1;
                  busy_o       <= 1'b1;
                  done_o       <= 1'b0;
                  wr_err_cnt_o <= '0;
                  rd_err_cnt_o <= '0;
`ifdef AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN
                  err_seen_q   <= 1'b0;
                  err_addr_o   <= '0;
                  err_data_o   <= '0;
`endif
               end
            e_write: begin
               if (awready_i) awvalid_o <= 1'b0;
               if (wready_i)  wvalid_o  <= 1'b0;
               if (aw_ok && w_ok) begin
                  state_q  <= e_write_resp;
                  bready_o <= 1'b1;
               end
            end
            e_write_resp:
               if (bvalid_i) begin
                  bready_o <= 1'b0;
                  if (bresp_i[1]) wr_err_cnt_o <= sat_inc16(wr_err_cnt_o);
                  if (is_last) begin
                     state_q   <= e_read_addr;
                     arvalid_o <= 1'b1;
                  end else begin
                     state_q   <= e_write;
                     awvalid_o <= 1'b1;
                     wvalid_o  <= 1'b1;
                  end
               end
            e_read_addr:
               if (arready_i) begin
                  arvalid_o <= 1'b0;
                  rready_o  <= 1'b1;
                  state_q   <= e_read_data;
               end
            e_read_data:
               if (rvalid_i) begin
                  rready_o <= 1'b0;
                  if (rd_bad || rresp_i[1]) rd_err_cnt_o <= sat_inc16(rd_err_cnt_o);
`ifdef AXIL_TRAFFIC_GEN_ERR_CAPTURE_EN
                  if (rd_bad && !err_seen_q) begin
                     err_seen_q <= 1'b1;
                     err_addr_o <= addr_q;
                     err_data_o <= rdata_i;
                  end
`endif
                  if (is_last) begin
                     state_q <= e_done;
                     busy_o  <= 1'b0;
                     done_o  <= 1'b1;
                  end else begin
                     state_q   <= e_read_addr;
                     arvalid_o <= 1'b1;
                  end
               end
            default: state_q <= e_idle;
         endcase
      end
   end

endmodule
